// File: rtl/disp_pkg.sv
// disp_pkg: shared state encoding, dark-bus constants and hex-to-segment decode for the display scanner
package disp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} disp_state_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b1000000;
            4'h1: hex2seg = 7'b1111001;
            4'h2: hex2seg = 7'b0100100;
            4'h3: hex2seg = 7'b0110000;
            4'h4: hex2seg = 7'b0011001;
            4'h5: hex2seg = 7'b0010010;
            4'h6: hex2seg = 7'b0000010;
            4'h7: hex2seg = 7'b1111000;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0010000;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b0000011;
            4'hC: hex2seg = 7'b1000110;
            4'hD: hex2seg = 7'b0100001;
            4'hE: hex2seg = 7'b0000110;
            default: hex2seg = 7'b0001110;
        endcase
    endfunction
endpackage

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit seven-segment scanner with dead-time blanking and per-frame latching; DISP_ZERO_BLANK_EN enables leading-zero suppression
module disp_scan_ctrl #(
    parameter int SHOW_TICKS  = 100_000,
    parameter int BLANK_TICKS = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);
    import disp_pkg::*;

    localparam int MAXT = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int CW = (MAXT > 2) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

    disp_state_t   state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [3:0]    sh [4];
    logic [3:0]    sh_dp;
    logic          reload;
    logic          supp;
    logic [3:0]    lit_an;
    logic [6:0]    lit_seg;
    logic          lit_dp;
`ifdef DISP_ZERO_BLANK_EN
    logic [3:0]    z;
`endif

    // Drive pattern for the digit about to be lit; suppressed leading zeros stay dark
    always_comb begin
`ifdef DISP_ZERO_BLANK_EN
        z[3] = sh[3] == 4'd0;
        z[2] = z[3] && sh[2] == 4'd0;
        z[1] = z[2] && sh[1] == 4'd0;
        z[0] = 1'b0;
        supp = z[idx];
`else
        supp = 1'b0;
`endif
        lit_an  = supp ? AN_OFF : ~(4'b0001 << idx);
        lit_seg = supp ? SEG_OFF : hex2seg(sh[idx]);
        lit_dp  = supp | ~sh_dp[idx];
        reload  = en && (state == IDLE || (state == SHOW && cnt == SHOW_LAST && idx == 2'd3));
    end

    // Shadow capture on every entry to BLANK with idx=0, pulsing frame_tick alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            sh         <= '{default: 4'd0};
            sh_dp      <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= reload;
            if (reload) begin
                sh    <= '{hex0, hex1, hex2, hex3};
                sh_dp <= dp_in;
            end
        end
    end

    // Scan FSM; outputs are loaded on the same edge that enters each state
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state <= BLANK;
                    idx   <= 2'd0;
                    cnt   <= '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= lit_an;
                        seg   <= lit_seg;
                        dp    <= lit_dp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with SHOW_TICKS=8, BLANK_TICKS=2
module tb_disp_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] hex0, hex1, hex2, hex3, dp_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;
    int checks = 0;
    int errors = 0;
`ifdef DISP_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SHOW_TICKS(8), .BLANK_TICKS(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed, input logic ef);
        checks++;
        assert ({an, seg, dp, frame_tick} === {ea, es, ed, ef}) else begin
            errors++;
            $error("FAIL %s: an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
                   tag, an, seg, dp, frame_tick, ea, es, ed, ef);
        end
    endtask

    task automatic blank_slot(input string tag, input bit first);
        for (int c = 0; c < 2; c++) begin
            step;
            chk(tag, 4'hF, 7'h7F, 1'b1, first && c == 0);
        end
    endtask

    task automatic show_slot(input string tag, input int k, input bit lit, input logic [6:0] es, input logic ed, input int n);
        logic [3:0] ea;
        ea = lit ? ~(4'b0001 << k) : 4'hF;
        for (int c = 0; c < n; c++) begin
            step;
            chk(tag, ea, lit ? es : 7'h7F, lit ? ed : 1'b1, 1'b0);
        end
    endtask

    task automatic frame(input string tag, input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [3:0] dpe, input logic [3:0] lit);
        logic [6:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            blank_slot(tag, k == 0);
            show_slot(tag, k, lit[k], s[k], dpe[k], 8);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        hex3 = 4'h3; hex2 = 4'h2; hex1 = 4'h1; hex0 = 4'h0; dp_in = 4'b0001;
        #1;
        repeat (3) begin
            step;
            chk("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        rst = 1'b0;
        frame("frame1", 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 4'b1110, 4'b1111);
        blank_slot("latch", 1'b1);
        show_slot("latch", 0, 1'b1, 7'b1000000, 1'b0, 8);
        blank_slot("latch", 1'b0);
        show_slot("latch", 1, 1'b1, 7'b1111001, 1'b1, 8);
        blank_slot("latch", 1'b0);
        show_slot("latch", 2, 1'b1, 7'b0100100, 1'b1, 3);
        hex0 = 4'hF;
        show_slot("latch", 2, 1'b1, 7'b0100100, 1'b1, 5);
        blank_slot("latch", 1'b0);
        show_slot("latch", 3, 1'b1, 7'b0110000, 1'b1, 8);
        frame("reloadF", 7'b0110000, 7'b0100100, 7'b1111001, 7'b0001110, 4'b1110, 4'b1111);
        blank_slot("en_drop", 1'b1);
        show_slot("en_drop", 0, 1'b1, 7'b0001110, 1'b0, 8);
        blank_slot("en_drop", 1'b0);
        show_slot("en_drop", 1, 1'b1, 7'b1111001, 1'b1, 3);
        en = 1'b0;
        step;
        chk("en_off", 4'hF, 7'h7F, 1'b1, 1'b0);
        step;
        chk("en_idle", 4'hF, 7'h7F, 1'b1, 1'b0);
        hex3 = 4'h0; hex2 = 4'h0; hex1 = 4'h5; hex0 = 4'h0;
        en = 1'b1;
        frame("zeros", 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000, 4'b1110, ZB ? 4'b0011 : 4'b1111);
        blank_slot("rst_mid", 1'b1);
        show_slot("rst_mid", 0, 1'b1, 7'b1000000, 1'b0, 8);
        blank_slot("rst_mid", 1'b0);
        show_slot("rst_mid", 1, 1'b1, 7'b0010010, 1'b1, 8);
        blank_slot("rst_mid", 1'b0);
        show_slot("rst_mid", 2, !ZB, 7'b1000000, 1'b1, 3);
        rst = 1'b1;
        hex3 = 4'h4; hex2 = 4'h6; hex1 = 4'h8; hex0 = 4'h9; dp_in = 4'b1010;
        step;
        chk("rst_apply", 4'hF, 7'h7F, 1'b1, 1'b0);
        step;
        chk("rst_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        frame("restart", 7'b0011001, 7'b0000010, 7'b0000000, 7'b0010000, 4'b0101, 4'b1111);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
